fractmem_arbiter: RTL and testbench
===================================

FRACTMEM_ARBITER -- requirements
Module: fractmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, meaning frame-memory address width.
REQ-002 SHALL have parameter DEPTH, default 19200, meaning pixel count (160x120).
REQ-003 SHALL have parameter WBUF_DEPTH, default 4, meaning write-buffer entries (power of two).
REQ-004 SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port disp_active  input  1  display scan in visible region.
REQ-007 SHALL have port disp_addr  input  ADDR_W  display read address.
REQ-008 SHALL have port disp_pixel  output  1  registered display pixel.
REQ-009 SHALL have port wr_valid  input  1  compute-engine write request.
REQ-010 SHALL have port wr_ready  output  1  write accepted when wr_valid and wr_ready are both high.
REQ-011 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-012 SHALL have port wr_data  input  1  write pixel.
REQ-013 SHALL have port clear_req  input  1  single-cycle frame-clear request.
REQ-014 SHALL have port clear_busy  output  1  clear pending or in progress.
REQ-015 SHALL have port clear_done  output  1  one-cycle pulse when clear completes.
REQ-016 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-017 SHALL have port mem_we  output  1  memory write enable.
REQ-018 SHALL have port mem_wdata  output  1  memory write data.
REQ-019 SHALL have port mem_rdata  input  1  memory read data, valid one cycle after address.

Function
REQ-020 SHALL grant the memory to the display whenever disp_active=1: mem_addr=disp_addr and mem_we=0, combinationally, with no exceptions.
REQ-021 SHALL register mem_rdata into disp_pixel one cycle after each display-granted cycle, giving disp_addr-to-disp_pixel latency of 2 cycles; otherwise disp_pixel SHALL hold its value.
REQ-022 SHALL buffer accepted writes in a WBUF_DEPTH-entry FIFO of {addr,data}, in order, with an occupancy count 0..WBUF_DEPTH.
REQ-023 SHALL drive wr_ready = (count<WBUF_DEPTH) AND state==IDLE.
REQ-024 SHALL pop one FIFO entry per cycle to memory (mem_we=1, mem_addr/mem_wdata from head) only when disp_active=0, count>0 and state is IDLE or DRAIN.
REQ-025 SHALL, on simultaneous push and pop, leave count unchanged and preserve FIFO order.
REQ-026 SHALL wrap FIFO read and write pointers modulo WBUF_DEPTH.
REQ-027 SHALL implement FSM states IDLE, DRAIN, CLEAR and DONE.
REQ-028 SHALL transition IDLE->DRAIN on clear_req=1.
REQ-029 SHALL transition DRAIN->CLEAR when count==0.
REQ-030 SHALL, in CLEAR, write 0 to address clr_cnt on each cycle with disp_active=0, then increment clr_cnt; disp_active=1 stalls clr_cnt.
REQ-031 SHALL transition CLEAR->DONE after writing address DEPTH-1.
REQ-032 SHALL transition DONE->IDLE unconditionally after one cycle, with clear_done=1 only in DONE.
REQ-033 SHALL reset clr_cnt to 0 on entry to CLEAR; clr_cnt SHALL never exceed DEPTH-1.
REQ-034 SHALL ignore clear_req in DRAIN, CLEAR and DONE, with no queuing.
REQ-035 SHALL drive clear_busy=1 in DRAIN and CLEAR.
REQ-036 SHALL drive mem_we=0, mem_addr=0 and mem_wdata=0 when idle with no grant.

Reset
REQ-037 SHALL, on rst_n=0 asynchronously: state=IDLE; FIFO pointers, count and clr_cnt=0; disp_pixel=0; clear_busy=0; clear_done=0; mem_we=0; wr_ready=0 while rst_n=0.
REQ-038 SHALL discard buffered writes and abort any clear when reset is asserted mid-operation, with no further memory writes until new requests arrive.

Verification
REQ-039 SHALL verify: disp_active=1, disp_addr=37, mem holds 1 at 37 -> mem_we=0 throughout and disp_pixel=1 two cycles later.
REQ-040 SHALL verify: 5 back-to-back writes with disp_active=1 -> 4 accepted, wr_ready=0 on the 5th; after disp_active falls, 4 writes in order on consecutive cycles.
REQ-041 SHALL verify: push and pop in the same cycle at count=2 -> count stays 2 and the memory write order matches acceptance order.
REQ-042 SHALL verify: clear_req with 3 buffered writes -> 3 writes first, then DEPTH zero writes over addresses 0..19199, clear_done pulse of 1 cycle, and clear_busy high throughout.
REQ-043 SHALL verify: disp_active toggling during CLEAR -> no write during active cycles and no skipped or repeated address.
REQ-044 SHALL verify: rst_n low at clr_cnt=500 -> immediate IDLE, outputs at reset values, and no further zero writes after release.

Source files
------------

// File: rtl/fractmem_arbiter.sv
// Single-port frame-memory arbiter: display reads have absolute priority, compute-engine
// writes are buffered in a small FIFO, and a frame clear zeroes every pixel in display gaps.
module fractmem_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DEPTH      = 19200,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_active,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_pixel,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_wdata,
    input  logic              mem_rdata
);

    localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(WBUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                disp_valid_q, disp_valid_d;
    logic                disp_pixel_q, disp_pixel_d;
    logic                clear_busy_q, clear_busy_d;
    logic                clear_done_q, clear_done_d;

    logic [ADDR_W-1:0]   fifo_addr_q [WBUF_DEPTH];
    logic                fifo_data_q [WBUF_DEPTH];

    logic                push;
    logic                pop;
    logic                clr_wr;

    // Writes are only accepted in IDLE so a clear never races with new pixels.
    assign wr_ready = rst_n && (count_q < CNT_W'(WBUF_DEPTH)) && (state_q == IDLE);
    assign push     = wr_valid && wr_ready;
    assign pop      = !disp_active && (count_q != '0) && ((state_q == IDLE) || (state_q == DRAIN));
    assign clr_wr   = !disp_active && (state_q == CLEAR);

    assign disp_pixel = disp_pixel_q;
    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 1'b0;
        if (disp_active) begin
            mem_addr = disp_addr;
        end else if (pop) begin
            mem_addr  = fifo_addr_q[rd_ptr_q];
            mem_we    = 1'b1;
            mem_wdata = fifo_data_q[rd_ptr_q];
        end else if (clr_wr) begin
            mem_addr = clr_cnt_q;
            mem_we   = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (count_q == '0) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                if (clr_wr) begin
                    if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
                    else                                 clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(WBUF_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(WBUF_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Read data arrives one cycle after a display grant, so the grant is delayed to match.
    always_comb begin
        disp_valid_d = disp_active;
        disp_pixel_d = disp_valid_q ? mem_rdata : disp_pixel_q;
        clear_busy_d = (state_d == DRAIN) || (state_d == CLEAR);
        clear_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            disp_valid_q <= 1'b0;
            disp_pixel_q <= 1'b0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            disp_valid_q <= disp_valid_d;
            disp_pixel_q <= disp_pixel_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_fractmem_arbiter.sv
// Directed self-checking bench for fractmem_arbiter with a behavioural 1-bit frame memory
// (registered read) and a log of every memory write seen at the clock edge.
module tb_fractmem_arbiter;

    localparam int ADDR_W = 19;
    localparam int DEPTH  = 19200;

    logic              clk;
    logic              rst_n;
    logic              disp_active;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_pixel;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;
    logic              clear_req;
    logic              clear_busy;
    logic              clear_done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_wdata;
    logic              mem_rdata;

    int testsRun  = 0;
    int failCount = 0;
    int weActiveCount = 0;

    bit                memArr [0:DEPTH-1];
    logic [ADDR_W-1:0] logAddr [$];
    logic              logData [$];

    fractmem_arbiter #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WBUF_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_active(disp_active), .disp_addr(disp_addr), .disp_pixel(disp_pixel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame memory model: synchronous write, read data valid one cycle after the address.
    always @(posedge clk) begin
        if (int'(mem_addr) < DEPTH) begin
            if (mem_we) memArr[int'(mem_addr)] <= mem_wdata;
            mem_rdata <= memArr[int'(mem_addr)];
        end else begin
            mem_rdata <= 1'b0;
        end
    end

    // Records every committed memory write and flags any write during a display grant.
    always @(posedge clk) begin
        if (rst_n && mem_we) begin
            logAddr.push_back(mem_addr);
            logData.push_back(mem_wdata);
            if (disp_active) weActiveCount++;
        end
    end

    // One cycle of stimulus: inputs change on the falling edge, checks follow 1 time unit later.
    task automatic applyStimulus(input logic da, input logic [ADDR_W-1:0] daddr,
                                 input logic wv, input logic [ADDR_W-1:0] waddr,
                                 input logic wd, input logic clr);
        @(negedge clk);
        disp_active = da;
        disp_addr   = daddr;
        wr_valid    = wv;
        wr_addr     = waddr;
        wr_data     = wd;
        clear_req   = clr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Checks that the write log from index start holds a full zero sweep of the frame.
    task automatic checkClearSweep(input string tag, input int start);
        int errs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (start + i >= logAddr.size()) begin
                errs++;
            end else if (logAddr[start + i] !== ADDR_W'(i) || logData[start + i] !== 1'b0) begin
                errs++;
            end
        end
        checkOutput(tag, errs, 0);
    endtask

    initial begin
        int logStart;
        bit doneSeen;
        int busyDrops;
        int doneCount;

        rst_n = 1'b0;
        disp_active = 1'b0; disp_addr = '0; wr_valid = 1'b0; wr_addr = '0;
        wr_data = 1'b0; clear_req = 1'b0;

        // Reset values while rst_n is held low
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_wr_ready", wr_ready, 0);
        checkOutput("rst_clear_busy", clear_busy, 0);
        checkOutput("rst_clear_done", clear_done, 0);
        checkOutput("rst_disp_pixel", disp_pixel, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("idle_wr_ready", wr_ready, 1);

        // Display read: store a 1 at 37, then read it back with 2-cycle latency
        applyStimulus(1'b0, '0, 1'b1, 19'd37, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("pre_wr_we", mem_we, 1);
        checkOutput("pre_wr_addr", mem_addr, 37);
        applyStimulus(1'b1, 19'd37, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("rd_mem_we", mem_we, 0);
        checkOutput("rd_mem_addr", mem_addr, 37);
        applyStimulus(1'b1, 19'd38, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("rd_mem_we2", mem_we, 0);
        checkOutput("rd_pixel_early", disp_pixel, 0);
        idleCycle();
        checkOutput("rd_pixel_2cyc", disp_pixel, 1);
        idleCycle();
        checkOutput("rd_pixel_next", disp_pixel, 0);

        // Five back-to-back writes during display: only four fit, drained in order afterwards
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 19'd5, 1'b1, ADDR_W'(100 + i), (i % 2 == 0), 1'b0);
            checkOutput($sformatf("fill_ready%0d", i), wr_ready, (i < 4));
            checkOutput($sformatf("fill_we%0d", i), mem_we, 0);
        end
        for (int i = 0; i < 4; i++) begin
            idleCycle();
            checkOutput($sformatf("drain_we%0d", i), mem_we, 1);
            checkOutput($sformatf("drain_addr%0d", i), mem_addr, 100 + i);
            checkOutput($sformatf("drain_data%0d", i), mem_wdata, (i % 2 == 0));
        end
        idleCycle();
        checkOutput("drain_empty_we", mem_we, 0);

        // Simultaneous push and pop at count 2 keeps count at 2 and preserves order
        applyStimulus(1'b1, '0, 1'b1, 19'd200, 1'b1, 1'b0);
        applyStimulus(1'b1, '0, 1'b1, 19'd201, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 19'd202, 1'b1, 1'b0);
        checkOutput("pp_ready", wr_ready, 1);
        checkOutput("pp_we", mem_we, 1);
        checkOutput("pp_addr", mem_addr, 200);
        checkOutput("pp_data", mem_wdata, 1);
        applyStimulus(1'b1, '0, 1'b1, 19'd203, 1'b0, 1'b0);
        checkOutput("pp_ready3", wr_ready, 1);
        applyStimulus(1'b1, '0, 1'b1, 19'd204, 1'b1, 1'b0);
        checkOutput("pp_ready4", wr_ready, 1);
        applyStimulus(1'b1, '0, 1'b1, 19'd205, 1'b0, 1'b0);
        checkOutput("pp_full", wr_ready, 0);
        for (int k = 1; k <= 4; k++) begin
            idleCycle();
            checkOutput($sformatf("pp_addr%0d", k), mem_addr, 200 + k);
            checkOutput($sformatf("pp_data%0d", k), mem_wdata, (k % 2 == 0));
        end
        idleCycle();
        checkOutput("pp_empty_we", mem_we, 0);

        // Clear with three buffered writes: writes drain first, then a full zero sweep
        logStart = logAddr.size();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, '0, 1'b1, ADDR_W'(300 + i), 1'b1, 1'b0);
        applyStimulus(1'b1, '0, 1'b0, '0, 1'b0, 1'b1);
        doneSeen = 0;
        busyDrops = 0;
        for (int n = 0; n < 25000 && !doneSeen; n++) begin
            idleCycle();
            if (clear_done) doneSeen = 1;
            else if (!clear_busy) busyDrops++;
        end
        checkOutput("clr_done_seen", doneSeen, 1);
        checkOutput("clr_busy_held", busyDrops, 0);
        checkOutput("clr_busy_in_done", clear_busy, 0);
        idleCycle();
        checkOutput("clr_done_width", clear_done, 0);
        checkOutput("clr_total_writes", logAddr.size() - logStart, 3 + DEPTH);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("clr_pre_addr%0d", i), logAddr[logStart + i], 300 + i);
            checkOutput($sformatf("clr_pre_data%0d", i), logData[logStart + i], 1);
        end
        checkClearSweep("clr_sweep", logStart + 3);

        // Clear with display toggling and a stray clear request mid-sweep
        logStart = logAddr.size();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        doneSeen = 0;
        doneCount = 0;
        for (int n = 0; n < 40000 && !doneSeen; n++) begin
            applyStimulus((n % 3 == 1), ADDR_W'(n % DEPTH), 1'b0, '0, 1'b0, (n == 100));
            if (clear_done) begin
                doneSeen = 1;
                doneCount++;
            end
        end
        checkOutput("tog_done_seen", doneSeen, 1);
        for (int i = 0; i < 5; i++) begin
            idleCycle();
            if (clear_done) doneCount++;
        end
        checkOutput("tog_done_once", doneCount, 1);
        checkOutput("tog_no_requeue", clear_busy, 0);
        checkOutput("tog_we_active", weActiveCount, 0);
        checkOutput("tog_total_writes", logAddr.size() - logStart, DEPTH);
        checkClearSweep("tog_sweep", logStart);

        // Reset mid-clear at clr_cnt 500 aborts the sweep for good
        logStart = logAddr.size();
        idleCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 2000 && (logAddr.size() - logStart) < 500; n++) idleCycle();
        checkOutput("rstmid_reached", logAddr.size() - logStart, 500);
        checkOutput("rstmid_busy_before", clear_busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_busy", clear_busy, 0);
        checkOutput("rstmid_we", mem_we, 0);
        checkOutput("rstmid_ready", wr_ready, 0);
        checkOutput("rstmid_done", clear_done, 0);
        checkOutput("rstmid_pixel", disp_pixel, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 50; n++) idleCycle();
        checkOutput("rstmid_no_writes", logAddr.size() - logStart, 500);
        checkOutput("rstmid_idle_busy", clear_busy, 0);
        checkOutput("rstmid_idle_ready", wr_ready, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
